// File: rtl/noc_credit_valrdy_bridge.sv
// noc_credit_valrdy_bridge
//
// Bridges NUM_CH credit-based (valid/yummy) NoC channels to valid/ready
// endpoints. Each channel is independent and has two paths.
//
// Inbound path (NoC to endpoint)
//   - An IN_DEPTH-entry FIFO feeds the endpoint.
//   - One yummy is returned to the NoC for every flit the endpoint pops.
//
// Outbound path (endpoint to NoC)
//   - A credit counter starts at OUT_CREDITS.
//   - It throttles the endpoint and is replenished by NoC yummies.
//
// Ports (channel c uses bit c, or bits [c*DATA_W +: DATA_W] for data)
//   clk, reset                   : single clock; synchronous active-high reset
//   cr_data_in / cr_valid_in     : inbound flits from the NoC
//   cr_yummy_out                 : credit return to the NoC, one pulse per pop
//   vr_data_out / vr_valid_out   : FIFO head towards the endpoint
//   vr_ready_out                 : endpoint accepts the head flit
//   vr_data_in / vr_valid_in     : outbound flits from the endpoint
//   vr_ready_in                  : bridge holds at least one outbound credit
//   cr_data_out / cr_valid_out   : registered outbound flit, one-cycle pulse
//   cr_yummy_in                  : credit return from the NoC
//   err_ovf                      : sticky, a flit arrived while the FIFO was full
//   err_cred                     : sticky, a yummy arrived with credits already full
module noc_credit_valrdy_bridge #(
    parameter int DATA_W      = 64,
    parameter int NUM_CH      = 3,
    parameter int IN_DEPTH    = 4,
    parameter int OUT_CREDITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] cr_data_in,
    input  logic [NUM_CH-1:0]        cr_valid_in,
    output logic [NUM_CH-1:0]        cr_yummy_out,
    output logic [NUM_CH*DATA_W-1:0] vr_data_out,
    output logic [NUM_CH-1:0]        vr_valid_out,
    input  logic [NUM_CH-1:0]        vr_ready_out,
    input  logic [NUM_CH*DATA_W-1:0] vr_data_in,
    input  logic [NUM_CH-1:0]        vr_valid_in,
    output logic [NUM_CH-1:0]        vr_ready_in,
    output logic [NUM_CH*DATA_W-1:0] cr_data_out,
    output logic [NUM_CH-1:0]        cr_valid_out,
    input  logic [NUM_CH-1:0]        cr_yummy_in,
    output logic [NUM_CH-1:0]        err_ovf,
    output logic [NUM_CH-1:0]        err_cred
);

    localparam int PTR_W  = $clog2(IN_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = $clog2(OUT_CREDITS + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(IN_DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OUT_CREDITS);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

        logic [DATA_W-1:0] mem_q [IN_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  count_q, count_d;
        logic              ovf_q, ovf_d;
        logic              yummy_q;
        logic              empty, full, push, pop, wr_en;

        logic [CRED_W-1:0] cred_q, cred_d;
        logic              cred_err_q, cred_err_d;
        logic              valid_out_q;
        logic [DATA_W-1:0] data_out_q;
        logic              ready, send;

        // Inbound FIFO control.
        // A push into a full FIFO is still accepted when a pop frees the
        // head slot in the same cycle. The write then lands on the slot
        // being read out: both pointers coincide when full. Only a push
        // into a full FIFO with no pop is dropped and flagged.
        always_comb begin
            empty    = (count_q == '0);
            full     = (count_q == DEPTH_C);
            push     = cr_valid_in[c];
            pop      = ~empty & vr_ready_out[c];
            wr_en    = push & (~full | pop);
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            ovf_d    = ovf_q;
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end
        end

        // Outbound credit accounting.
        // A send and a yummy in the same cycle cancel out. A yummy that
        // would push the count above its initial value is a protocol
        // error: the count holds and the error is flagged.
        always_comb begin
            ready      = (cred_q != '0) & ~reset;
            send       = vr_valid_in[c] & ready;
            cred_d     = cred_q;
            cred_err_d = cred_err_q;
            if (send && !cr_yummy_in[c]) begin
                cred_d = cred_q - 1'b1;
            end else if (!send && cr_yummy_in[c]) begin
                if (cred_q == CRED_MAX) begin
                    cred_err_d = 1'b1;
                end else begin
                    cred_d = cred_q + 1'b1;
                end
            end
        end

        // FIFO storage needs no reset: the output is masked to zero
        // while the FIFO is empty.
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= cr_data_in[c*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                ovf_q       <= 1'b0;
                yummy_q     <= 1'b0;
                cred_q      <= CRED_MAX;
                cred_err_q  <= 1'b0;
                valid_out_q <= 1'b0;
                data_out_q  <= '0;
            end else begin
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                count_q     <= count_d;
                ovf_q       <= ovf_d;
                yummy_q     <= pop;
                cred_q      <= cred_d;
                cred_err_q  <= cred_err_d;
                valid_out_q <= send;
                if (send) begin
                    data_out_q <= vr_data_in[c*DATA_W +: DATA_W];
                end
            end
        end

        assign vr_valid_out[c]                   = ~empty;
        assign vr_data_out[c*DATA_W +: DATA_W]   = empty ? '0 : mem_q[rd_ptr_q];
        assign cr_yummy_out[c]                   = yummy_q;
        assign vr_ready_in[c]                    = ready;
        assign cr_valid_out[c]                   = valid_out_q;
        assign cr_data_out[c*DATA_W +: DATA_W]   = data_out_q;
        assign err_ovf[c]                        = ovf_q;
        assign err_cred[c]                       = cred_err_q;
    end

endmodule

// File: tb/tb_noc_credit_valrdy_bridge.sv
// tb_noc_credit_valrdy_bridge
//
// Directed and constrained-random stimulus for noc_credit_valrdy_bridge.
// A queue/integer model of every channel tracks the expected outputs.
// A negedge process compares all DUT outputs against that model.
// Literal expectations in the directed sequence pin the model itself.
module tb_noc_credit_valrdy_bridge;

    localparam int DATA_W      = 64;
    localparam int NUM_CH      = 3;
    localparam int IN_DEPTH    = 4;
    localparam int OUT_CREDITS = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_CH*DATA_W-1:0] cr_data_in = '0;
    logic [NUM_CH-1:0]        cr_valid_in = '0;
    logic [NUM_CH-1:0]        cr_yummy_out;
    logic [NUM_CH*DATA_W-1:0] vr_data_out;
    logic [NUM_CH-1:0]        vr_valid_out;
    logic [NUM_CH-1:0]        vr_ready_out = '0;
    logic [NUM_CH*DATA_W-1:0] vr_data_in = '0;
    logic [NUM_CH-1:0]        vr_valid_in = '0;
    logic [NUM_CH-1:0]        vr_ready_in;
    logic [NUM_CH*DATA_W-1:0] cr_data_out;
    logic [NUM_CH-1:0]        cr_valid_out;
    logic [NUM_CH-1:0]        cr_yummy_in = '0;
    logic [NUM_CH-1:0]        err_ovf;
    logic [NUM_CH-1:0]        err_cred;

    int cmpCount = 0;
    int errCount = 0;

    noc_credit_valrdy_bridge #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .IN_DEPTH    (IN_DEPTH),
        .OUT_CREDITS (OUT_CREDITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cr_data_in   (cr_data_in),
        .cr_valid_in  (cr_valid_in),
        .cr_yummy_out (cr_yummy_out),
        .vr_data_out  (vr_data_out),
        .vr_valid_out (vr_valid_out),
        .vr_ready_out (vr_ready_out),
        .vr_data_in   (vr_data_in),
        .vr_valid_in  (vr_valid_in),
        .vr_ready_in  (vr_ready_in),
        .cr_data_out  (cr_data_out),
        .cr_valid_out (cr_valid_out),
        .cr_yummy_in  (cr_yummy_in),
        .err_ovf      (err_ovf),
        .err_cred     (err_cred)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] slice(input logic [NUM_CH*DATA_W-1:0] v, input int c);
        return v[c*DATA_W +: DATA_W];
    endfunction

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string name, input int ch, input logic [63:0] got, input logic [63:0] want);
        cmpCount++;
        if (got !== want) begin
            errCount++;
            $display("[TB] FAIL %s ch=%0d got=%h want=%h at %0t", name, ch, got, want, $time);
        end
    endtask

    // Advance n clock edges. Control returns 1 time unit after the last
    // edge, so registered outputs have settled and new inputs can be driven.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model: one flit queue, one integer credit count and
    // the expected registered outputs, per channel.
    logic [DATA_W-1:0] mQ [NUM_CH][$];
    int                mCred [NUM_CH];
    bit                mOvf [NUM_CH];
    bit                mErrCred [NUM_CH];
    bit                mYummy [NUM_CH];
    bit                mValidOut [NUM_CH];
    logic [DATA_W-1:0] mDataOut [NUM_CH];
    bit                modelArmed = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (reset) begin
                    mQ[c].delete();
                    mCred[c]     = OUT_CREDITS;
                    mOvf[c]      = 1'b0;
                    mErrCred[c]  = 1'b0;
                    mYummy[c]    = 1'b0;
                    mValidOut[c] = 1'b0;
                    mDataOut[c]  = '0;
                end else if (modelArmed) begin
                    automatic bit popNow  = (mQ[c].size() > 0) && vr_ready_out[c];
                    automatic bit wasFull = (mQ[c].size() == IN_DEPTH);
                    automatic bit sendNow = vr_valid_in[c] && (mCred[c] > 0);
                    mYummy[c] = popNow;
                    if (popNow) begin
                        void'(mQ[c].pop_front());
                    end
                    if (cr_valid_in[c]) begin
                        if (!wasFull || popNow) begin
                            mQ[c].push_back(slice(cr_data_in, c));
                        end else begin
                            mOvf[c] = 1'b1;
                        end
                    end
                    mValidOut[c] = sendNow;
                    if (sendNow) begin
                        mDataOut[c] = slice(vr_data_in, c);
                    end
                    if (sendNow && !cr_yummy_in[c]) begin
                        mCred[c]--;
                    end else if (!sendNow && cr_yummy_in[c]) begin
                        if (mCred[c] == OUT_CREDITS) begin
                            mErrCred[c] = 1'b1;
                        end else begin
                            mCred[c]++;
                        end
                    end
                end
            end
            if (reset) begin
                modelArmed = 1'b1;
            end
        end
    end

    // Every cycle once the model is armed, compare every output of every channel.
    initial begin
        forever begin
            @(negedge clk);
            if (modelArmed) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    checkOutput("m_vr_valid_out", c, 64'(vr_valid_out[c]), 64'(mQ[c].size() > 0));
                    checkOutput("m_vr_data_out", c, slice(vr_data_out, c),
                                (mQ[c].size() > 0) ? mQ[c][0] : 64'h0);
                    checkOutput("m_cr_yummy_out", c, 64'(cr_yummy_out[c]), 64'(mYummy[c]));
                    checkOutput("m_vr_ready_in", c, 64'(vr_ready_in[c]), 64'((mCred[c] != 0) && !reset));
                    checkOutput("m_cr_valid_out", c, 64'(cr_valid_out[c]), 64'(mValidOut[c]));
                    checkOutput("m_cr_data_out", c, slice(cr_data_out, c), mDataOut[c]);
                    checkOutput("m_err_ovf", c, 64'(err_ovf[c]), 64'(mOvf[c]));
                    checkOutput("m_err_cred", c, 64'(err_cred[c]), 64'(mErrCred[c]));
                end
            end
        end
    end

    // Directed sequence followed by concurrent random traffic.
    logic [DATA_W-1:0] drainExp [4];
    int                upCred [NUM_CH];
    int                popCnt [NUM_CH];
    int                yumCnt [NUM_CH];

    initial begin
        drainExp = '{64'hA2, 64'hA3, 64'hA4, 64'hAA};

        // Reset state
        reset = 1'b1;
        applyStimulus(2);
        checkOutput("rst_ready_in_during_reset", -1, 64'(vr_ready_in), 64'h0);
        checkOutput("rst_vr_valid_out", -1, 64'(vr_valid_out), 64'h0);
        checkOutput("rst_cr_valid_out", -1, 64'(cr_valid_out), 64'h0);
        checkOutput("rst_cr_data_out", 0, slice(cr_data_out, 0), 64'h0);
        reset = 1'b0;
        #1;
        checkOutput("rst_ready_in_after", -1, 64'(vr_ready_in), 64'h7);

        // Fill ch0 with 0x11..0x14 while the endpoint is stalled
        for (int i = 0; i < 4; i++) begin
            cr_valid_in[0] = 1'b1;
            cr_data_in[0 +: DATA_W] = 64'(8'h11 + i);
            applyStimulus(1);
        end
        checkOutput("fill_valid", 0, 64'(vr_valid_out[0]), 64'h1);
        checkOutput("fill_head", 0, slice(vr_data_out, 0), 64'h11);
        cr_data_in[0 +: DATA_W] = 64'h15;
        applyStimulus(1);
        cr_valid_in[0] = 1'b0;
        checkOutput("ovf_flag", 0, 64'(err_ovf[0]), 64'h1);
        checkOutput("ovf_head_kept", 0, slice(vr_data_out, 0), 64'h11);

        // Drain in order, each pop returning a yummy one cycle later
        vr_ready_out[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_head", 0, slice(vr_data_out, 0), 64'(8'h11 + i));
            applyStimulus(1);
            checkOutput("drain_yummy", 0, 64'(cr_yummy_out[0]), 64'h1);
        end
        checkOutput("drain_empty", 0, 64'(vr_valid_out[0]), 64'h0);
        checkOutput("drain_data_zero", 0, slice(vr_data_out, 0), 64'h0);
        vr_ready_out[0] = 1'b0;
        applyStimulus(1);
        checkOutput("drain_yummy_end", 0, 64'(cr_yummy_out[0]), 64'h0);

        // Push and pop together while full
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cr_valid_in[0] = 1'b1;
            cr_data_in[0 +: DATA_W] = 64'(8'hA1 + i);
            applyStimulus(1);
        end
        cr_data_in[0 +: DATA_W] = 64'hAA;
        vr_ready_out[0] = 1'b1;
        checkOutput("full_pp_head", 0, slice(vr_data_out, 0), 64'hA1);
        applyStimulus(1);
        cr_valid_in[0] = 1'b0;
        checkOutput("full_pp_no_ovf", 0, 64'(err_ovf[0]), 64'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("full_pp_order", 0, slice(vr_data_out, 0), drainExp[i]);
            applyStimulus(1);
        end
        checkOutput("full_pp_empty", 0, 64'(vr_valid_out[0]), 64'h0);
        vr_ready_out[0] = 1'b0;

        // Outbound: three credits, then stall
        vr_valid_in[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vr_data_in[0 +: DATA_W] = 64'(16'h200 + i);
            checkOutput("out_ready", 0, 64'(vr_ready_in[0]), 64'(i < 3));
            applyStimulus(1);
            checkOutput("out_valid", 0, 64'(cr_valid_out[0]), 64'(i < 3));
        end
        checkOutput("out_data_hold", 0, slice(cr_data_out, 0), 64'h202);

        // One yummy re-enables exactly one send
        cr_yummy_in[0] = 1'b1;
        applyStimulus(1);
        cr_yummy_in[0] = 1'b0;
        vr_data_in[0 +: DATA_W] = 64'h300;
        checkOutput("yum_ready", 0, 64'(vr_ready_in[0]), 64'h1);
        applyStimulus(1);
        checkOutput("yum_send", 0, 64'(cr_valid_out[0]), 64'h1);
        checkOutput("yum_data", 0, slice(cr_data_out, 0), 64'h300);
        checkOutput("yum_ready_gone", 0, 64'(vr_ready_in[0]), 64'h0);
        applyStimulus(1);
        checkOutput("yum_single", 0, 64'(cr_valid_out[0]), 64'h0);

        // Send and yummy together keep the credit count at 1
        vr_valid_in[0] = 1'b0;
        cr_yummy_in[0] = 1'b1;
        applyStimulus(1);
        vr_valid_in[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("sy_ready", 0, 64'(vr_ready_in[0]), 64'h1);
            applyStimulus(1);
            checkOutput("sy_valid", 0, 64'(cr_valid_out[0]), 64'h1);
        end
        cr_yummy_in[0] = 1'b0;
        applyStimulus(1);
        checkOutput("sy_last_send_drains", 0, 64'(vr_ready_in[0]), 64'h0);
        vr_valid_in[0] = 1'b0;

        // Refill to 3, then an extra yummy is a credit error
        cr_yummy_in[0] = 1'b1;
        applyStimulus(3);
        checkOutput("cred_full_no_err", 0, 64'(err_cred[0]), 64'h0);
        applyStimulus(1);
        cr_yummy_in[0] = 1'b0;
        checkOutput("cred_err", 0, 64'(err_cred[0]), 64'h1);
        vr_valid_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("cred_held_at_3", 0, 64'(vr_ready_in[0]), 64'(i < 3));
            applyStimulus(1);
        end
        vr_valid_in[0] = 1'b0;

        // Reset mid-traffic: ch1 holds 2 flits and has no credits
        vr_data_in[DATA_W +: DATA_W] = 64'h61;
        vr_valid_in[1] = 1'b1;
        cr_valid_in[1] = 1'b1;
        cr_data_in[DATA_W +: DATA_W] = 64'h51;
        applyStimulus(1);
        cr_data_in[DATA_W +: DATA_W] = 64'h52;
        applyStimulus(1);
        cr_valid_in[1] = 1'b0;
        applyStimulus(1);
        vr_valid_in[1] = 1'b0;
        checkOutput("pre_rst_valid1", 1, 64'(vr_valid_out[1]), 64'h1);
        checkOutput("pre_rst_ready1", 1, 64'(vr_ready_in[1]), 64'h0);
        checkOutput("pre_rst_data1", 1, slice(cr_data_out, 1), 64'h61);
        reset = 1'b1;
        cr_valid_in[1] = 1'b1;
        cr_data_in[DATA_W +: DATA_W] = 64'h53;
        vr_ready_out[1] = 1'b1;
        cr_yummy_in[1] = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        cr_valid_in[1] = 1'b0;
        vr_ready_out[1] = 1'b0;
        cr_yummy_in[1] = 1'b0;
        #1;
        checkOutput("mid_rst_valid1", 1, 64'(vr_valid_out[1]), 64'h0);
        checkOutput("mid_rst_ready", -1, 64'(vr_ready_in), 64'h7);
        checkOutput("mid_rst_ovf", -1, 64'(err_ovf), 64'h0);
        checkOutput("mid_rst_cred_err", -1, 64'(err_cred), 64'h0);
        checkOutput("mid_rst_yummy", -1, 64'(cr_yummy_out), 64'h0);
        checkOutput("mid_rst_data1", 1, slice(cr_data_out, 1), 64'h0);
        applyStimulus(1);
        checkOutput("mid_rst_yummy_next", -1, 64'(cr_yummy_out), 64'h0);
        vr_valid_in[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("mid_rst_cred3", 1, 64'(vr_ready_in[1]), 64'(i < 3));
            applyStimulus(1);
        end
        vr_valid_in[1] = 1'b0;

        // Concurrent random traffic on all channels
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            upCred[c] = IN_DEPTH;
            popCnt[c] = 0;
            yumCnt[c] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                yumCnt[c] += int'(cr_yummy_out[c]);
                upCred[c] += int'(cr_yummy_out[c]);
                cr_yummy_in[c] = cr_valid_out[c];
                if (upCred[c] > 0 && $urandom_range(0, 3) != 0) begin
                    cr_valid_in[c] = 1'b1;
                    cr_data_in[c*DATA_W +: DATA_W] = {8'(c), 24'($urandom), 32'($urandom)};
                    upCred[c]--;
                end else begin
                    cr_valid_in[c] = 1'b0;
                end
                vr_ready_out[c] = 1'($urandom_range(0, 1));
                vr_valid_in[c] = 1'($urandom_range(0, 1));
                vr_data_in[c*DATA_W +: DATA_W] = {8'(8'h10 + c), 24'($urandom), 32'($urandom)};
                if (vr_valid_out[c] && vr_ready_out[c]) begin
                    popCnt[c]++;
                end
            end
            applyStimulus(1);
        end
        cr_valid_in = '0;
        vr_ready_out = '0;
        vr_valid_in = '0;
        cr_yummy_in = '0;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                yumCnt[c] += int'(cr_yummy_out[c]);
            end
            applyStimulus(1);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checkOutput("rand_yummy_eq_pop", c, 64'(yumCnt[c]), 64'(popCnt[c]));
            checkOutput("rand_some_pops", c, 64'(popCnt[c] > 20), 64'h1);
        end
        checkOutput("rand_no_ovf", -1, 64'(err_ovf), 64'h0);
        checkOutput("rand_no_cred_err", -1, 64'(err_cred), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/noc_credit_valrdy_bridge.md
# noc_credit_valrdy_bridge

Parametrised, multi-channel bridge between the credit-based (valid/yummy) NoC links and the valid/ready interfaces of chipset-side endpoints such as the fake memory controller. It replaces the fixed pairing of one credit-to-valrdy converter for the inbound direction and one valrdy-to-credit converter for the outbound direction. Each of NUM_CH channels gets an inbound FIFO of configurable depth and an outbound credit counter of configurable size, plus sticky protocol-error flags. It sits between the chip-side NoC channels and chipset endpoints.

## Interface

Parameters:
- DATA_W, 64: flit width, matching the NoC data width.
- NUM_CH, 3: number of NoC channels bridged, from 1 to 8.
- IN_DEPTH, 4: entries in each inbound FIFO, a power of two from 2 to 16.
- OUT_CREDITS, 3: initial outbound credits per channel, from 1 to 15.

Ports (channel c occupies bit c, or bits [c*DATA_W +: DATA_W]):
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- cr_data_in  in  NUM_CH*DATA_W  inbound flits from the NoC.
- cr_valid_in  in  NUM_CH  inbound flit valid.
- cr_yummy_out  out  NUM_CH  credit return to the NoC, one pulse per freed entry.
- vr_data_out  out  NUM_CH*DATA_W  inbound flit to the endpoint (FIFO head).
- vr_valid_out  out  NUM_CH  FIFO not empty.
- vr_ready_out  in  NUM_CH  endpoint accepts the head flit.
- vr_data_in  in  NUM_CH*DATA_W  outbound flit from the endpoint.
- vr_valid_in  in  NUM_CH  outbound flit valid.
- vr_ready_in  out  NUM_CH  bridge can accept an outbound flit.
- cr_data_out  out  NUM_CH*DATA_W  outbound flit to the NoC.
- cr_valid_out  out  NUM_CH  outbound flit valid, one-cycle pulse per flit.
- cr_yummy_in  in  NUM_CH  credit return from the NoC.
- err_ovf  out  NUM_CH  sticky flag: inbound flit arrived while the FIFO was full.
- err_cred  out  NUM_CH  sticky flag: yummy received while credits were already at OUT_CREDITS.

## Operation

Channels are fully independent; there is no arbitration between them.

Inbound path, per channel:
- push = cr_valid_in. pop = vr_valid_out & vr_ready_out.
- FIFO with a count of $clog2(IN_DEPTH)+1 bits and wrapping read and write pointers.
- Push with the FIFO not full: write at the write pointer, then advance it.
- Push while full with no pop in the same cycle: drop the flit, set err_ovf, leave FIFO contents unchanged.
- Push while full with a simultaneous pop: both take effect and the count is unchanged. This is not an error.
- vr_data_out is the entry at the read pointer. It must read as 0 when empty.
- Each pop produces exactly one cr_yummy_out pulse.

Outbound path, per channel:
- Credit counter cred, $clog2(OUT_CREDITS+1) bits, reset to OUT_CREDITS.
- vr_ready_in = (cred != 0) & ~reset.
- send = vr_valid_in & vr_ready_in.
- Next cred value:
  - cred - send + cr_yummy_in in the normal case.
  - Send and yummy in the same cycle: cred unchanged.
  - Yummy without send while cred == OUT_CREDITS: cred holds, err_cred is set.
- A send registers vr_data_in into cr_data_out and asserts cr_valid_out for exactly one cycle.
- cr_data_out holds its last value while cr_valid_out is low.

Error flags:
- Sticky until reset. Cleared only by reset.

## Timing

- Reset (assert at any time, including mid-transfer): on the next edge
  - all FIFOs are emptied and pointers zeroed;
  - cred = OUT_CREDITS;
  - cr_yummy_out, cr_valid_out, vr_valid_out, err_ovf and err_cred = 0;
  - cr_data_out = 0.
  - vr_ready_in is 0 while reset is high and 1 on the first cycle after reset.
  - In-flight flits are discarded. No yummy is returned for them.
- Inbound latency: a flit pushed at edge T is visible on vr_valid_out and vr_data_out after edge T. There is no same-cycle bypass.
- Yummy latency: a pop in cycle T gives cr_yummy_out high in cycle T+1 (registered).
- Outbound latency: a send in cycle T gives cr_valid_out in cycle T+1.
- Credit effect: a yummy in cycle T can re-enable vr_ready_in in cycle T+1.
- Throughput: one flit per cycle per direction per channel. Sustained outbound rate requires OUT_CREDITS to cover the round-trip yummy latency.

## Test plan

- Reset, then stream 4 flits (0x11..0x14) into ch0 with vr_ready_out=0 and IN_DEPTH=4:
  - vr_valid_out=1 and the head is 0x11;
  - a 5th flit 0x15 sets err_ovf[0], and the FIFO still holds 0x11..0x14.
- Then set vr_ready_out=1 for 4 cycles:
  - data appears in order 0x11..0x14;
  - 4 cr_yummy_out[0] pulses, each one cycle after its pop;
  - vr_valid_out drops after the 4th pop.
- FIFO full, with push 0xAA and pop in the same cycle:
  - the count stays at 4, err_ovf stays 0, and 0xAA is dequeued last.
- Outbound with OUT_CREDITS=3, vr_valid_in held high and no yummies:
  - 3 sends, then vr_ready_in=0;
  - cr_valid_out pulses in cycles 1-3 after the first send.
- Then one cr_yummy_in:
  - vr_ready_in=1 next cycle and exactly one more send occurs.
- Send and yummy in the same cycle keep cred constant.
- A yummy at cred=3 sets err_cred, and cred stays 3.
- Assert reset for one cycle with ch1's FIFO holding 2 flits and cred=0:
  - next cycle vr_valid_out[1]=0, cred=3, vr_ready_in=1, all error flags 0, and no yummy pulses.
- NUM_CH=3 with concurrent traffic on all channels, compared against per-channel scoreboards:
  - no cross-channel data mixing;
  - yummy count equals pop count per channel.
